// File: rtl/alu_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_arbiter
// Description : Lets NREQ issue slots share one combinational alu instance.
//               Requests are arbitrated round-robin, and one operation is
//               issued per cycle. The granted slot's operands and opcode
//               drive the alu. The alu result is captured, tagged with the
//               slot index, into a one-entry registered response stage.
// Ports       : clk         - clock; all state updates on the rising edge
//               resetN      - asynchronous active-low reset
//               reqValid    - per-slot request pending
//               reqReady    - one-hot grant (issue when valid & ready)
//               reqA/reqB   - per-slot operands, packed OPERANDSIZE each
//               reqOp       - per-slot operationSelect, packed OPSELWIDTH each
//               aluA/aluB   - operands to the shared alu
//               aluOp       - operationSelect to the shared alu
//               aluQ        - combinational result from the shared alu
//               rspValid    - response register holds a result
//               rspReady    - consumer takes the response this cycle
//               rspId       - slot that issued the held result
//               rspQ        - held result
//               rspIllegal  - held result came from a non ADD/XOR/AND/OR op
//               busyCount   - saturating count of issued operations
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_arbiter #(
    parameter int OPERANDSIZE = 64,
    parameter int NREQ        = 4,
    parameter int OPSELWIDTH  = 12
) (
    input  logic                        clk,
    input  logic                        resetN,
    input  logic [NREQ-1:0]             reqValid,
    output logic [NREQ-1:0]             reqReady,
    input  logic [NREQ*OPERANDSIZE-1:0] reqA,
    input  logic [NREQ*OPERANDSIZE-1:0] reqB,
    input  logic [NREQ*OPSELWIDTH-1:0]  reqOp,
    output logic [OPERANDSIZE-1:0]      aluA,
    output logic [OPERANDSIZE-1:0]      aluB,
    output logic [OPSELWIDTH-1:0]       aluOp,
    input  logic [OPERANDSIZE-1:0]      aluQ,
    output logic                        rspValid,
    input  logic                        rspReady,
    output logic [$clog2(NREQ)-1:0]     rspId,
    output logic [OPERANDSIZE-1:0]      rspQ,
    output logic                        rspIllegal,
    output logic [31:0]                 busyCount
);

    localparam int IDWIDTH = $clog2(NREQ);
    // One extra bit so rrPtr + offset (up to 2*NREQ-1) never wraps early
    localparam int c_SUMW  = IDWIDTH + 1;
    localparam logic [IDWIDTH-1:0]    c_PTR_RESET = IDWIDTH'(NREQ - 1);
    localparam logic [OPSELWIDTH-1:0] c_LAST_LEGAL_OP = OPSELWIDTH'(3);

    // ------------------------------------------------------------------
    // Slot payload unpacking
    // ------------------------------------------------------------------
    logic [OPERANDSIZE-1:0] w_slotA  [NREQ];
    logic [OPERANDSIZE-1:0] w_slotB  [NREQ];
    logic [OPSELWIDTH-1:0]  w_slotOp [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_slotA[gi]  = reqA[gi*OPERANDSIZE +: OPERANDSIZE];
            assign w_slotB[gi]  = reqB[gi*OPERANDSIZE +: OPERANDSIZE];
            assign w_slotOp[gi] = reqOp[gi*OPSELWIDTH +: OPSELWIDTH];
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [IDWIDTH-1:0]     r_rrPtr;
    logic                   r_rspValid;
    logic [IDWIDTH-1:0]     r_rspId;
    logic [OPERANDSIZE-1:0] r_rspQ;
    logic                   r_rspIllegal;
    logic [31:0]            r_busyCount;

    // ------------------------------------------------------------------
    // Round-robin search starting just after the last issued slot
    // ------------------------------------------------------------------
    logic               w_found;
    logic [IDWIDTH-1:0] w_winner;
    logic [c_SUMW-1:0]  w_sum;
    logic [IDWIDTH-1:0] w_cand;

    always_comb begin : p_arb
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        w_cand   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            w_sum = {1'b0, r_rrPtr} + c_SUMW'(i);
            if (w_sum >= c_SUMW'(NREQ)) begin
                w_sum = w_sum - c_SUMW'(NREQ);
            end
            w_cand = w_sum[IDWIDTH-1:0];
            if (!w_found && reqValid[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    // Response slot is free, or is being drained on this same edge.
    // Gated by resetN so no grant is shown while reset is held.
    logic            w_canIssue;
    logic [NREQ-1:0] w_grant;
    logic            w_issue;

    assign w_canIssue = resetN & (~r_rspValid | rspReady);
    assign w_grant    = (w_found && w_canIssue) ? (NREQ'(1) << w_winner) : '0;
    assign w_issue    = |(reqValid & w_grant);
    assign reqReady   = w_grant;

    // The winner's payload drives the alu even while stalled, so that the
    // alu output is already settled when the stall releases.
    assign aluA  = w_found ? w_slotA[w_winner]  : '0;
    assign aluB  = w_found ? w_slotB[w_winner]  : '0;
    assign aluOp = w_found ? w_slotOp[w_winner] : '0;

    // ------------------------------------------------------------------
    // Response register, pointer and issue counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_rrPtr      <= c_PTR_RESET;
            r_rspValid   <= 1'b0;
            r_rspId      <= '0;
            r_rspQ       <= '0;
            r_rspIllegal <= 1'b0;
            r_busyCount  <= '0;
        end else if (w_issue) begin
            r_rspValid   <= 1'b1;
            r_rspQ       <= aluQ;
            r_rspId      <= w_winner;
            r_rspIllegal <= (aluOp > c_LAST_LEGAL_OP);
            r_rrPtr      <= w_winner;
            if (r_busyCount != 32'hFFFF_FFFF) begin
                r_busyCount <= r_busyCount + 32'd1;
            end
        end else if (r_rspValid && rspReady) begin
            r_rspValid <= 1'b0;
        end
    end

    assign rspValid   = r_rspValid;
    assign rspId      = r_rspId;
    assign rspQ       = r_rspQ;
    assign rspIllegal = r_rspIllegal;
    assign busyCount  = r_busyCount;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_arbiter
// Description : Directed bench for alu_issue_arbiter. Stimulus pushes the
//               hand-computed expected response whenever a grant is
//               expected. A separate monitor pops and compares each
//               response as it is handed off (rspValid & rspReady).
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_arbiter;

    localparam int W  = 64;
    localparam int N  = 4;
    localparam int OW = 12;

    logic              clk = 1'b0;
    logic              resetN;
    logic [N-1:0]      reqValid;
    logic [N-1:0]      reqReady;
    logic [N*W-1:0]    reqA;
    logic [N*W-1:0]    reqB;
    logic [N*OW-1:0]   reqOp;
    logic [W-1:0]      aluA;
    logic [W-1:0]      aluB;
    logic [OW-1:0]     aluOp;
    logic [W-1:0]      aluQ;
    logic              rspValid;
    logic              rspReady;
    logic [1:0]        rspId;
    logic [W-1:0]      rspQ;
    logic              rspIllegal;
    logic [31:0]       busyCount;

    always #5 clk = ~clk;

    alu_issue_arbiter #(.OPERANDSIZE(W), .NREQ(N), .OPSELWIDTH(OW)) dut (
        .clk        (clk),
        .resetN     (resetN),
        .reqValid   (reqValid),
        .reqReady   (reqReady),
        .reqA       (reqA),
        .reqB       (reqB),
        .reqOp      (reqOp),
        .aluA       (aluA),
        .aluB       (aluB),
        .aluOp      (aluOp),
        .aluQ       (aluQ),
        .rspValid   (rspValid),
        .rspReady   (rspReady),
        .rspId      (rspId),
        .rspQ       (rspQ),
        .rspIllegal (rspIllegal),
        .busyCount  (busyCount)
    );

    // Stand-in for the shared combinational alu
    always_comb begin
        aluQ = '0;
        case (aluOp)
            12'd0:   aluQ = aluA + aluB;
            12'd1:   aluQ = aluA ^ aluB;
            12'd2:   aluQ = aluA & aluB;
            12'd3:   aluQ = aluA | aluB;
            default: aluQ = '0;
        endcase
    end

    typedef struct packed {
        logic [1:0]   id;
        logic [W-1:0] q;
        logic         ill;
    } rsp_t;

    rsp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [1:0] id_of(input logic [N-1:0] oh);
        logic [1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (oh[i]) r = 2'(i);
        end
        return r;
    endfunction

    task automatic set_slot(input int s, input logic [OW-1:0] op,
                            input logic [W-1:0] a, input logic [W-1:0] b);
        reqOp[s*OW +: OW] = op;
        reqA[s*W +: W]    = a;
        reqB[s*W +: W]    = b;
    endtask

    // Called right after inputs are driven for the cycle
    task automatic expect_grant(input logic [N-1:0] g, input logic [W-1:0] q,
                                input logic ill, input string nm);
        rsp_t e;
        #1;
        chk(nm, 64'(reqReady), 64'(g));
        if (g != '0) begin
            e.id  = id_of(g);
            e.q   = q;
            e.ill = ill;
            sb.push_back(e);
        end
    endtask

    // Monitor: compares each handed-off response with the queue head
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (resetN && rspValid && rspReady) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rsp: got id=%0d q=%0h want none", rspId, rspQ);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_id",  64'(rspId),      64'(e.id));
                    chk("rsp_q",   rspQ,            e.q);
                    chk("rsp_ill", 64'(rspIllegal), 64'(e.ill));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        resetN   = 1'b0;
        reqValid = '1;
        rspReady = 1'b1;
        reqA     = '0;
        reqB     = '0;
        reqOp    = '0;
        for (int s = 0; s < N; s++) set_slot(s, 12'd1, 64'h33, 64'h11);

        // Reset with every slot requesting
        repeat (2) @(negedge clk);
        #1;
        chk("rst_reqReady", 64'(reqReady), 64'd0);
        chk("rst_rspValid", 64'(rspValid), 64'd0);
        chk("rst_busy",     64'(busyCount), 64'd0);

        // Idle: no requests, alu inputs forced to zero
        @(negedge clk);
        resetN   = 1'b1;
        reqValid = '0;
        #1;
        chk("idle_reqReady", 64'(reqReady), 64'd0);
        chk("idle_aluA",     aluA, 64'd0);
        chk("idle_aluOp",    64'(aluOp), 64'd0);

        // Single request on slot 2: 5 + 7
        @(negedge clk);
        set_slot(2, 12'd0, 64'd5, 64'd7);
        reqValid = 4'b0100;
        expect_grant(4'b0100, 64'd12, 1'b0, "single_grant");
        @(negedge clk);
        reqValid = '0;
        #1;
        chk("single_rspValid", 64'(rspValid), 64'd1);
        chk("single_busy",     64'(busyCount), 64'd1);

        // Round robin from a fresh reset
        @(negedge clk);
        resetN = 1'b0;
        #1;
        @(negedge clk);
        resetN = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            for (int s = 0; s < N; s++) set_slot(s, 12'd0, 64'(s*16 + 1), 64'd100);
            reqValid = '1;
            expect_grant(4'(1 << (k % 4)), 64'((k % 4)*16 + 101), 1'b0, "rr_grant");
        end
        @(negedge clk);
        reqValid = '0;
        #1;
        chk("rr_busy", 64'(busyCount), 64'd8);

        // Backpressure: slot 0 issues, consumer stalls 5 cycles
        @(negedge clk);
        reqValid = '1;
        expect_grant(4'b0001, 64'd101, 1'b0, "bp_first");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            rspReady = 1'b0;
            #1;
            chk("bp_reqReady", 64'(reqReady), 64'd0);
            chk("bp_rspId",    64'(rspId), 64'd0);
            chk("bp_rspQ",     rspQ, 64'd101);
        end
        @(negedge clk);
        rspReady = 1'b1;
        expect_grant(4'b0010, 64'd117, 1'b0, "bp_resume");
        @(negedge clk);
        reqValid = '0;
        #1;
        chk("bp_busy", 64'(busyCount), 64'd10);

        // Operation coverage on slot 3, back to back
        @(negedge clk);
        set_slot(3, 12'd1, 64'hFF, 64'h0F);
        reqValid = 4'b1000;
        expect_grant(4'b1000, 64'hF0, 1'b0, "op_xor");
        @(negedge clk);
        set_slot(3, 12'd2, 64'hFF, 64'h0F);
        expect_grant(4'b1000, 64'h0F, 1'b0, "op_and");
        @(negedge clk);
        set_slot(3, 12'd3, 64'hFF, 64'h0F);
        expect_grant(4'b1000, 64'hFF, 1'b0, "op_or");
        @(negedge clk);
        set_slot(3, 12'd9, 64'hFF, 64'h0F);
        expect_grant(4'b1000, 64'h0, 1'b1, "op_illegal");
        @(negedge clk);
        reqValid = '0;

        // Async reset with a response pending and rrPtr = 1
        @(negedge clk);
        set_slot(1, 12'd0, 64'd3, 64'd4);
        reqValid = 4'b0010;
        expect_grant(4'b0010, 64'd7, 1'b0, "pre_rst_grant");
        @(negedge clk);
        reqValid = '0;
        rspReady = 1'b0;
        #1;
        chk("pre_rst_rspValid", 64'(rspValid), 64'd1);
        #1;
        resetN = 1'b0;
        sb.delete();
        #1;
        chk("async_rst_rspValid", 64'(rspValid), 64'd0);
        @(negedge clk);
        resetN   = 1'b1;
        rspReady = 1'b1;
        for (int s = 0; s < N; s++) set_slot(s, 12'd0, 64'(s*16 + 1), 64'd100);
        reqValid = '1;
        expect_grant(4'b0001, 64'd101, 1'b0, "post_rst_grant");
        @(negedge clk);
        reqValid = '0;

        repeat (3) @(negedge clk);
        #4;
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
